// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if: serial bit stream in (x, en) and match outputs (z, match_cnt).
// The match_cnt signal exists only when SEQ_DET_MATCH_CNT_EN is defined.
interface seq_detect_param_if #(
  parameter int CNT_W = 8
);
  logic x;
  logic en;
  logic z;

  // A zero-width counter cannot be declared.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_detect_param_if: CNT_W must be >= 1");
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt;

  modport master (output x, en, input z, match_cnt);
  modport slave  (input x, en, output z, match_cnt);
`else
  modport master (output x, en, input z);
  modport slave  (input x, en, output z);
`endif
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised Moore serial pattern detector.
// PATTERN[N-1] is the first bit received. OVERLAP selects whether the tail of a
// match may seed the next one. The next-state table is built at elaboration
// time, so the runtime logic is only a table lookup and a state register.
// Optional feature macro: SEQ_DET_MATCH_CNT_EN adds a saturating match counter.
module seq_detect_param #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b0110,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  seq_detect_param_if.slave  bus
);

  // State width holds S0..SN.
  localparam int SW    = $clog2(N + 1);
  localparam int TBL_W = (N + 1) * 2 * SW;

  localparam logic [SW-1:0] S0 = '0;
  localparam logic [SW-1:0] SN = SW'(N);

  // Reject parameter sets that fall outside the supported range.
  if (N < 2 || N > 16) begin : g_bad_n
    $error("seq_detect_param: N must be in 2..16");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_detect_param: CNT_W must be >= 1");
  end

  // Build the next-state table. Entry (k, b) holds the length of the longest
  // pattern prefix that is a suffix of (prefix of length k followed by b).
  // With OVERLAP=0, the full-match state restarts as if from S0.
  function automatic logic [TBL_W-1:0] build_tbl();
    logic [TBL_W-1:0] tbl;
    logic [16:0]      s;
    int               k_eff;
    int               len;
    int               best;
    bit               ok;
    tbl = '0;
    s   = '0;
    for (int k = 0; k <= N; k++) begin
      for (int b = 0; b < 2; b++) begin
        k_eff = (k == N && !OVERLAP) ? 0 : k;
        len   = k_eff + 1;
        // Consumed history: the matched prefix followed by the new bit.
        for (int i = 0; i < k_eff; i++) s[i] = PATTERN[N-1-i];
        s[k_eff] = b[0];
        // Pick the longest prefix that ends the history; j never exceeds N.
        best = 0;
        for (int j = 1; j <= N; j++) begin
          if (j <= len) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++)
              if (PATTERN[N-1-t] != s[len-j+t]) ok = 1'b0;
            if (ok) best = j;
          end
        end
        tbl[(k*2+b)*SW +: SW] = SW'(best);
      end
    end
    return tbl;
  endfunction

  localparam logic [TBL_W-1:0] TBL = build_tbl();

  logic [SW-1:0] state;
  logic [SW-1:0] nxt;
  logic [SW:0]   idx;
  logic          hit;
  logic          z_q;

  // Look up the successor state for the current state and incoming bit.
  always_comb begin
    idx = {state, bus.x};
    nxt = TBL[idx*SW +: SW];
    hit = (nxt == SN);
  end

  // State register: bits are consumed only on enabled edges, so x is never
  // sampled while idle.
  always_ff @(posedge clk) begin
    if (reset)       state <= S0;
    else if (bus.en) state <= nxt;
  end

  // Registered Moore flag, tracks state == SN and holds through idle cycles.
  always_ff @(posedge clk) begin
    if (reset)       z_q <= 1'b0;
    else if (bus.en) z_q <= hit;
  end

  assign bus.z = z_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating match counter; stops at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset)                        cnt_q <= '0;
    else if (bus.en && hit && ~&cnt_q) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: drives one shared bit stream into six detector builds
// (different patterns, lengths, overlap modes and counter widths) and checks
// every output after each edge against a tail-of-history reference model.
module tb_seq_detect_param;

  localparam int ND = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic x = 1'b0;
  logic en = 1'b0;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-build configuration, mirrored by the instances below.
  int          pn   [ND] = '{4, 4, 4, 4, 7, 3};
  logic [15:0] ppat [ND] = '{16'b0110, 16'b0110, 16'b1111, 16'b1111, 16'b1001001, 16'b101};
  bit          povl [ND] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  int          pcw  [ND] = '{8, 8, 2, 8, 8, 8};

  // Reference model state: bit history, bits consumed since the last restart,
  // expected match flag and expected counter.
  logic [31:0] hist  [ND];
  int          since [ND];
  bit          mz    [ND];
  int          mc    [ND];

  seq_detect_param_if #(.CNT_W(8)) if0 ();
  seq_detect_param_if #(.CNT_W(8)) if1 ();
  seq_detect_param_if #(.CNT_W(2)) if2 ();
  seq_detect_param_if #(.CNT_W(8)) if3 ();
  seq_detect_param_if #(.CNT_W(8)) if4 ();
  seq_detect_param_if #(.CNT_W(8)) if5 ();

  seq_detect_param #(.N(4), .PATTERN(4'b0110), .OVERLAP(1'b1), .CNT_W(8))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  seq_detect_param #(.N(4), .PATTERN(4'b0110), .OVERLAP(1'b0), .CNT_W(8))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  seq_detect_param #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2))
    u2 (.clk(clk), .reset(reset), .bus(if2));
  seq_detect_param #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b0), .CNT_W(8))
    u3 (.clk(clk), .reset(reset), .bus(if3));
  seq_detect_param #(.N(7), .PATTERN(7'b1001001), .OVERLAP(1'b1), .CNT_W(8))
    u4 (.clk(clk), .reset(reset), .bus(if4));
  seq_detect_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8))
    u5 (.clk(clk), .reset(reset), .bus(if5));

  assign if0.x = x;  assign if0.en = en;
  assign if1.x = x;  assign if1.en = en;
  assign if2.x = x;  assign if2.en = en;
  assign if3.x = x;  assign if3.en = en;
  assign if4.x = x;  assign if4.en = en;
  assign if5.x = x;  assign if5.en = en;

  logic [ND-1:0] zv;
  assign zv = {if5.z, if4.z, if3.z, if2.z, if1.z, if0.z};

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [7:0] mcv [ND];
  assign mcv[0] = if0.match_cnt;
  assign mcv[1] = if1.match_cnt;
  assign mcv[2] = {6'b0, if2.match_cnt};
  assign mcv[3] = if3.match_cnt;
  assign mcv[4] = if4.match_cnt;
  assign mcv[5] = if5.match_cnt;
`endif

  // Drive one cycle of inputs, then advance the reference model. A match is
  // "the last N consumed bits equal the pattern", counting only bits since the
  // last restart (reset, or a match when overlap is off).
  task automatic step(input bit r, input bit e, input bit b);
    logic [31:0] mask;
    bit          m;
    @(negedge clk);
    reset = r; en = e; x = b;
    @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      if (r) begin
        hist[i] = '0; since[i] = 0; mz[i] = 1'b0; mc[i] = 0;
      end else if (e) begin
        mask     = (32'h1 << pn[i]) - 32'h1;
        hist[i]  = {hist[i][30:0], b};
        if (since[i] < 64) since[i] = since[i] + 1;
        m        = (since[i] >= pn[i]) && ((hist[i] & mask) == {16'b0, ppat[i]});
        mz[i]    = m;
        if (m && mc[i] < (1 << pcw[i]) - 1) mc[i] = mc[i] + 1;
        if (m && !povl[i]) since[i] = 0;
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (zv[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_z dut%0d: got %b want 0", i, zv[i]);
      end
`ifdef SEQ_DET_MATCH_CNT_EN
      n_cmp++;
      if (mcv[i] !== 8'd0) begin
        n_bad++;
        $display("FAIL reset_cnt dut%0d: got %0d want 0", i, mcv[i]);
      end
`endif
    end
  endtask

  // Fixed stream 0110110 then 0110, continuous enable.
  task automatic test_stream();
    bit s [$] = '{0, 1, 1, 0, 1, 1, 0, 0, 1, 1, 0};
    step(1'b1, 1'b0, 1'b0);
    foreach (s[k]) begin
      step(1'b0, 1'b1, s[k]);
      for (int i = 0; i < ND; i++) begin
        n_cmp++;
        if (zv[i] !== mz[i]) begin
          n_bad++;
          $display("FAIL stream_z dut%0d bit%0d: got %b want %b", i, k, zv[i], mz[i]);
        end
`ifdef SEQ_DET_MATCH_CNT_EN
        n_cmp++;
        if (int'(mcv[i]) !== mc[i]) begin
          n_bad++;
          $display("FAIL stream_cnt dut%0d bit%0d: got %0d want %0d", i, k, mcv[i], mc[i]);
        end
`endif
      end
    end
    // Spot check independent of the model: 0110 overlap build counted 3 hits.
    n_cmp++;
    if (zv[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL stream_end_z dut0: got %b want 1", zv[0]);
    end
  endtask

  // 0110 with three idle cycles (random x) between valid bits.
  task automatic test_en_gaps();
    bit s [$] = '{0, 1, 1, 0};
    step(1'b1, 1'b0, 1'b0);
    foreach (s[k]) begin
      step(1'b0, 1'b1, s[k]);
      for (int g = 0; g < 4; g++) begin
        for (int i = 0; i < ND; i++) begin
          n_cmp++;
          if (zv[i] !== mz[i]) begin
            n_bad++;
            $display("FAIL gaps_z dut%0d bit%0d gap%0d: got %b want %b", i, k, g, zv[i], mz[i]);
          end
        end
        if (g < 3) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  // 011, reset, 0 (no match), then 0110 (match).
  task automatic test_mid_reset();
    bit s [$] = '{0, 1, 1, 0, 0, 1, 1, 0};
    bit r [$] = '{0, 0, 0, 1, 0, 0, 0, 0};
    foreach (s[k]) begin
      step(r[k], 1'b1, s[k]);
      for (int i = 0; i < ND; i++) begin
        n_cmp++;
        if (zv[i] !== mz[i]) begin
          n_bad++;
          $display("FAIL midrst_z dut%0d step%0d: got %b want %b", i, k, zv[i], mz[i]);
        end
`ifdef SEQ_DET_MATCH_CNT_EN
        n_cmp++;
        if (int'(mcv[i]) !== mc[i]) begin
          n_bad++;
          $display("FAIL midrst_cnt dut%0d step%0d: got %0d want %0d", i, k, mcv[i], mc[i]);
        end
`endif
      end
    end
  endtask

  // Run of ones: overlap 1111 stays high, non-overlap pulses; the 2-bit
  // counter on the overlap build saturates.
  task automatic test_ones();
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < ND; i++) begin
        n_cmp++;
        if (zv[i] !== mz[i]) begin
          n_bad++;
          $display("FAIL ones_z dut%0d bit%0d: got %b want %b", i, k, zv[i], mz[i]);
        end
`ifdef SEQ_DET_MATCH_CNT_EN
        n_cmp++;
        if (int'(mcv[i]) !== mc[i]) begin
          n_bad++;
          $display("FAIL ones_cnt dut%0d bit%0d: got %0d want %0d", i, k, mcv[i], mc[i]);
        end
`endif
      end
    end
`ifdef SEQ_DET_MATCH_CNT_EN
    n_cmp++;
    if (mcv[2] !== 8'd3) begin
      n_bad++;
      $display("FAIL ones_sat dut2: got %0d want 3", mcv[2]);
    end
`endif
  endtask

  // Random bits, random enable, occasional reset.
  task automatic test_random();
    bit r, e, b;
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 99) < 70);
      b = 1'($urandom_range(0, 1));
      step(r, e, b);
      for (int i = 0; i < ND; i++) begin
        n_cmp++;
        if (zv[i] !== mz[i]) begin
          n_bad++;
          $display("FAIL rand_z dut%0d cyc%0d: got %b want %b", i, k, zv[i], mz[i]);
        end
`ifdef SEQ_DET_MATCH_CNT_EN
        n_cmp++;
        if (int'(mcv[i]) !== mc[i]) begin
          n_bad++;
          $display("FAIL rand_cnt dut%0d cyc%0d: got %0d want %0d", i, k, mcv[i], mc[i]);
        end
`endif
      end
    end
  endtask

  initial begin
    for (int i = 0; i < ND; i++) begin
      hist[i] = '0; since[i] = 0; mz[i] = 1'b0; mc[i] = 0;
    end
    test_reset();
    test_stream();
    test_en_gaps();
    test_mid_reset();
    test_ones();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
